// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - requester, fill-control and framebuffer write signals of fb_write_arbiter
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              cpu_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_ready;
  logic              aux_valid;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_data;
  logic              aux_ready;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              fb_we;

  modport master (
    output cpu_valid, cpu_addr, cpu_data, aux_valid, aux_addr, aux_data,
           fill_start, fill_value,
    input  cpu_ready, aux_ready, fill_busy, fill_done, fb_addr, fb_data, fb_we
  );

  modport slave (
    input  cpu_valid, cpu_addr, cpu_data, aux_valid, aux_addr, aux_data,
           fill_start, fill_value,
    output cpu_ready, aux_ready, fill_busy, fill_done, fb_addr, fb_data, fb_we
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin CPU/AUX/FILL arbiter for the framebuffer write port; FB_ARB_FILL_EN enables the fill engine
module fb_write_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int FB_DEPTH   = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  fb_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SRC_CPU  = 2'd0,
    SRC_AUX  = 2'd1,
    SRC_FILL = 2'd2,
    SRC_NONE = 2'd3
  } src_t;

  src_t rr_ptr;
  src_t grant;

  // ---------------- CPU write FIFO ----------------
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              cpu_ready;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign cpu_ready     = (count != CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (count != '0);
  assign push          = bus.cpu_valid & cpu_ready;
  assign pop           = (grant == SRC_CPU);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cpu_addr;
      fifo_data[wr_ptr] <= bus.cpu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- fill engine ----------------
  logic              fill_busy;
  logic [ADDR_W-1:0] fill_idx;
  logic [DATA_W-1:0] fill_val;
  logic              fill_last;

`ifdef FB_ARB_FILL_EN
  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_BUSY = 1'b1
  } fill_state_t;

  fill_state_t       fill_state;
  fill_state_t       fill_state_nxt;
  logic [ADDR_W-1:0] fill_idx_nxt;
  logic [DATA_W-1:0] fill_val_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state <= FILL_IDLE;
      fill_idx   <= '0;
      fill_val   <= '0;
    end else begin
      fill_state <= fill_state_nxt;
      fill_idx   <= fill_idx_nxt;
      fill_val   <= fill_val_nxt;
    end
  end

  always_comb begin
    fill_state_nxt = fill_state;
    fill_idx_nxt   = fill_idx;
    fill_val_nxt   = fill_val;
    case (fill_state)
      FILL_IDLE: begin
        if (bus.fill_start) begin
          fill_state_nxt = FILL_BUSY;
          fill_idx_nxt   = '0;
          fill_val_nxt   = bus.fill_value;
        end
      end
      FILL_BUSY: begin
        // A start request while busy is deliberately not looked at here.
        if (grant == SRC_FILL) begin
          if (fill_last) fill_state_nxt = FILL_IDLE;
          else           fill_idx_nxt   = fill_idx + 1'b1;
        end
      end
      default: fill_state_nxt = FILL_IDLE;
    endcase
  end

  assign fill_busy = (fill_state == FILL_BUSY);
`else
  wire unused_fill_inputs = ^{bus.fill_start, bus.fill_value};

  assign fill_busy = 1'b0;
  assign fill_idx  = '0;
  assign fill_val  = '0;
`endif

  assign fill_last = (fill_idx == ADDR_W'(FB_DEPTH - 1));

  // ---------------- round-robin grant ----------------
  function automatic src_t next_src(input src_t s);
`ifdef FB_ARB_FILL_EN
    case (s)
      SRC_CPU: next_src = SRC_AUX;
      SRC_AUX: next_src = SRC_FILL;
      default: next_src = SRC_CPU;
    endcase
`else
    case (s)
      SRC_CPU: next_src = SRC_AUX;
      default: next_src = SRC_CPU;
    endcase
`endif
  endfunction

  logic [3:0] reqs;
  src_t       cand;

  always_comb begin
    reqs  = {1'b0, fill_busy, bus.aux_valid, fifo_nonempty};
    grant = SRC_NONE;
    cand  = rr_ptr;
    for (int i = 0; i < 3; i++) begin
      if (grant == SRC_NONE && reqs[cand]) grant = cand;
      cand = next_src(cand);
    end
  end

  // rr_ptr names the source searched first; it moves only when someone is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rr_ptr <= SRC_CPU;
    else if (grant != SRC_NONE) rr_ptr <= next_src(grant);
  end

  // ---------------- registered framebuffer port ----------------
  logic [ADDR_W-1:0] fb_addr_q;
  logic [DATA_W-1:0] fb_data_q;
  logic              fb_we_q;
  logic              fill_done_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_addr = fb_addr_q;
    wr_data = fb_data_q;
    case (grant)
      SRC_CPU: begin
        wr_addr = fifo_addr[rd_ptr];
        wr_data = fifo_data[rd_ptr];
      end
      SRC_AUX: begin
        wr_addr = bus.aux_addr;
        wr_data = bus.aux_data;
      end
      SRC_FILL: begin
        wr_addr = fill_idx;
        wr_data = fill_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      fb_we_q     <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      fb_addr_q   <= wr_addr;
      fb_data_q   <= wr_data;
      fb_we_q     <= (grant != SRC_NONE);
      fill_done_q <= (grant == SRC_FILL) && fill_last;
    end
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.aux_ready = (grant == SRC_AUX);
  assign bus.fill_busy = fill_busy;
  assign bus.fill_done = fill_done_q;
  assign bus.fb_addr   = fb_addr_q;
  assign bus.fb_data   = fb_data_q;
  assign bus.fb_we     = fb_we_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int FB_DEPTH   = 16;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(FB_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_valid  = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_data   = '0;
    bus.aux_valid  = 1'b0;
    bus.aux_addr   = '0;
    bus.aux_data   = '0;
    bus.fill_start = 1'b0;
    bus.fill_value = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
    end
  endtask

  typedef struct {
    logic        cv;
    logic [11:0] ca;
    logic [7:0]  cd;
    logic        av;
    logic [11:0] aa;
    logic [7:0]  ad;
    logic        e_cready;
    logic        e_aready;
    logic        e_we;
    logic [11:0] e_addr;
    logic [7:0]  e_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, seen, aux_acc, aux_seen, pending;
    bit prev_we, prev_cpu, cur_cpu, saw_full;
    int fill_seen, done_cnt, prev_src, cur_src;

    vecs[0]  = '{1'b1, 12'h100, 8'h11, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00};
    vecs[1]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h200, 8'h22, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00};
    vecs[2]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h200, 8'h22, 1'b1, 1'b1, 1'b1, 12'h100, 8'h11};
    vecs[3]  = '{1'b1, 12'h101, 8'h12, 1'b1, 12'h201, 8'h23, 1'b1, 1'b1, 1'b1, 12'h200, 8'h22};
    vecs[4]  = '{1'b1, 12'h102, 8'h13, 1'b1, 12'h202, 8'h24, 1'b1, 1'b0, 1'b1, 12'h201, 8'h23};
    vecs[5]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h202, 8'h24, 1'b1, 1'b1, 1'b1, 12'h101, 8'h12};
    vecs[6]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h202, 8'h24};
    vecs[7]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h102, 8'h13};
    vecs[8]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h102, 8'h13};
    vecs[9]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h3ff, 8'hff, 1'b1, 1'b1, 1'b0, 12'h102, 8'h13};
    vecs[10] = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h3ff, 8'hff};
    vecs[11] = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h3ff, 8'hff};

    // reset state
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    check("reset_fb_we", bus.fb_we, 0);
    check("reset_cpu_ready", bus.cpu_ready, 1);
    check("reset_aux_ready", bus.aux_ready, 0);
    check("reset_fill_busy", bus.fill_busy, 0);
    check("reset_fill_done", bus.fill_done, 0);
    check("reset_fb_addr", bus.fb_addr, 0);
    check("reset_fb_data", bus.fb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven CPU/AUX interleaving
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.cpu_valid = vecs[i].cv;
      bus.cpu_addr  = vecs[i].ca;
      bus.cpu_data  = vecs[i].cd;
      bus.aux_valid = vecs[i].av;
      bus.aux_addr  = vecs[i].aa;
      bus.aux_data  = vecs[i].ad;
      #1;
      check($sformatf("vec%0d_cpu_ready", i), bus.cpu_ready, vecs[i].e_cready);
      check($sformatf("vec%0d_aux_ready", i), bus.aux_ready, vecs[i].e_aready);
      check($sformatf("vec%0d_fb_we", i), bus.fb_we, vecs[i].e_we);
      check($sformatf("vec%0d_fb_addr", i), bus.fb_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_fb_data", i), bus.fb_data, vecs[i].e_data);
      check($sformatf("vec%0d_fill_busy", i), bus.fill_busy, 0);
      check($sformatf("vec%0d_fill_done", i), bus.fill_done, 0);
    end

    // CPU burst of six, nothing else requesting
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      idle_inputs();
      bus.cpu_valid = (cyc < 6);
      bus.cpu_addr  = 12'(cyc);
      bus.cpu_data  = 8'(8'h10 + cyc);
      #1;
      if (cyc < 6) check($sformatf("burst%0d_cpu_ready", cyc), bus.cpu_ready, 1);
      check($sformatf("burst%0d_fb_we", cyc), bus.fb_we, (cyc >= 2 && cyc < 8));
      if (cyc >= 2 && cyc < 8) begin
        check($sformatf("burst%0d_fb_addr", cyc), bus.fb_addr, cyc - 2);
        check($sformatf("burst%0d_fb_data", cyc), bus.fb_data, 8'h10 + cyc - 2);
      end
    end

    // FIFO fills while AUX requests continuously (fill_start held when the engine is absent)
    acc = 0; seen = 0; aux_acc = 0; aux_seen = 0;
    prev_we = 0; prev_cpu = 0; saw_full = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      idle_inputs();
      bus.cpu_valid = (acc < 8);
      bus.cpu_addr  = 12'(12'h400 + acc);
      bus.cpu_data  = 8'(8'h40 + acc);
      bus.aux_valid = 1'b1;
      bus.aux_addr  = 12'(12'h800 + aux_acc);
      bus.aux_data  = 8'(8'h80 + aux_acc);
`ifndef FB_ARB_FILL_EN
      bus.fill_start = 1'b1;
      bus.fill_value = 8'h99;
`endif
      #1;
      cur_cpu = 0;
      if (bus.fb_we) begin
        if (bus.fb_addr >= 12'h800) begin
          check("full_aux_addr", bus.fb_addr, 12'h800 + aux_seen);
          check("full_aux_data", bus.fb_data, 8'(8'h80 + aux_seen));
          aux_seen++;
        end else begin
          cur_cpu = 1;
          check("full_cpu_addr", bus.fb_addr, 12'h400 + seen);
          check("full_cpu_data", bus.fb_data, 8'(8'h40 + seen));
          seen++;
        end
        if (prev_we && prev_cpu) check("full_aux_after_cpu", cur_cpu, 0);
      end
      pending = acc - seen;
      check("full_cpu_ready", bus.cpu_ready, (pending != FIFO_DEPTH));
`ifndef FB_ARB_FILL_EN
      check("off_fill_busy", bus.fill_busy, 0);
      check("off_fill_done", bus.fill_done, 0);
`endif
      if (!bus.cpu_ready) saw_full = 1;
      if (bus.cpu_valid && bus.cpu_ready) acc++;
      if (bus.aux_ready) aux_acc++;
      prev_we  = bus.fb_we;
      prev_cpu = cur_cpu;
    end
    check("full_cpu_writes", seen, 8);
    check("full_saw_full", saw_full, 1);
    check("full_aux_writes_nonzero", (aux_seen > 4), 1);
    idle_cycles(4);

    // asynchronous reset with a full FIFO (and an active fill when built in)
    saw_full = 0;
    for (int cyc = 0; cyc < 20 && !saw_full; cyc++) begin
      @(negedge clk);
      idle_inputs();
      bus.cpu_valid  = 1'b1;
      bus.cpu_addr   = 12'h500;
      bus.cpu_data   = 8'h5a;
      bus.aux_valid  = 1'b1;
      bus.aux_addr   = 12'h900;
      bus.aux_data   = 8'ha5;
      bus.fill_start = (cyc == 0);
      bus.fill_value = 8'h77;
      #1;
      if (!bus.cpu_ready) saw_full = 1;
    end
    check("rst_fifo_was_full", saw_full, 1);
`ifdef FB_ARB_FILL_EN
    check("rst_fill_was_busy", bus.fill_busy, 1);
`endif
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_mid_fb_we", bus.fb_we, 0);
    check("rst_mid_cpu_ready", bus.cpu_ready, 1);
    check("rst_mid_aux_ready", bus.aux_ready, 0);
    check("rst_mid_fill_busy", bus.fill_busy, 0);
    check("rst_mid_fill_done", bus.fill_done, 0);
    check("rst_mid_fb_addr", bus.fb_addr, 0);
    check("rst_mid_fb_data", bus.fb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      #1;
      check("rst_after_no_write", bus.fb_we, 0);
      check("rst_after_no_done", bus.fill_done, 0);
    end

`ifdef FB_ARB_FILL_EN
    // three-way contention, plus a restart attempt mid-fill that must be ignored
    acc = 0; aux_acc = 0; fill_seen = 0; done_cnt = 0; prev_src = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      idle_inputs();
      bus.cpu_valid  = 1'b1;
      bus.cpu_addr   = 12'(12'h400 + (acc % 256));
      bus.cpu_data   = 8'(8'h40 + acc);
      bus.aux_valid  = 1'b1;
      bus.aux_addr   = 12'(12'h800 + (aux_acc % 256));
      bus.aux_data   = 8'(8'h80 + aux_acc);
      bus.fill_start = (cyc == 5) || (cyc == 20);
      bus.fill_value = (cyc == 5) ? 8'h20 : 8'h55;
      #1;
      if (cyc == 6) check("fill3_busy_after_start", bus.fill_busy, 1);
      if (bus.fill_done) done_cnt++;
      if (bus.fb_we) begin
        if (bus.fb_addr >= 12'h800)      cur_src = 1;
        else if (bus.fb_addr >= 12'h400) cur_src = 0;
        else                             cur_src = 2;
        if (fill_seen >= 1 && fill_seen < FB_DEPTH)
          check("fill3_rotation", cur_src, (prev_src + 1) % 3);
        if (cur_src == 2) begin
          check("fill3_addr", bus.fb_addr, fill_seen);
          check("fill3_data", bus.fb_data, 8'h20);
          check("fill3_done_on_last", bus.fill_done, (fill_seen == FB_DEPTH - 1));
          fill_seen++;
        end else begin
          check("fill3_no_done_other", bus.fill_done, 0);
        end
        prev_src = cur_src;
      end
      if (bus.cpu_valid && bus.cpu_ready) acc++;
      if (bus.aux_ready) aux_acc++;
    end
    check("fill3_cells", fill_seen, FB_DEPTH);
    check("fill3_done_count", done_cnt, 1);
    check("fill3_idle_after", bus.fill_busy, 0);
    idle_cycles(12);

    // uncontended fill
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      idle_inputs();
      bus.fill_start = (cyc == 0);
      bus.fill_value = 8'h33;
      #1;
      check($sformatf("fill1_%0d_busy", cyc), bus.fill_busy, (cyc >= 1 && cyc <= FB_DEPTH));
      check($sformatf("fill1_%0d_we", cyc), bus.fb_we, (cyc >= 2 && cyc <= FB_DEPTH + 1));
      check($sformatf("fill1_%0d_done", cyc), bus.fill_done, (cyc == FB_DEPTH + 1));
      if (cyc >= 2 && cyc <= FB_DEPTH + 1) begin
        check($sformatf("fill1_%0d_addr", cyc), bus.fb_addr, cyc - 2);
        check($sformatf("fill1_%0d_data", cyc), bus.fb_data, 8'h33);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
